// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared encodings and payload types for the store buffer.
//   Store size encodings (st_size_e), byte-enable constants and the
//   pre-aligned data/byte-enable lane stored in each FIFO entry.
package store_buffer_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = DATA_W / 8;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } st_size_e;

   localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;
   localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
   localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
   localparam logic [BE_W-1:0] BE_BYTE0   = 4'b0001;

   // Write payload as it will appear on the memory port.
   typedef struct packed {
      logic [DATA_W-1:0] wdata;
      logic [BE_W-1:0]   be;
   } sb_lane_t;

endpackage : store_buffer_pkg

// File: rtl/store_align.sv
// store_align: combinational store alignment for the push path.
//   addr    in  2   low byte-address bits
//   size    in  2   00 byte, 01 half, 10 word, 11 reserved
//   data    in  32  right-justified store data
//   wdata   out 32  data replicated across its lanes
//   be      out 4   little-endian byte enables
//   aligned out 1   request is naturally aligned (reserved size never is)
module store_align
   import store_buffer_pkg::*;
(
   input  logic [1:0]        addr,
   input  logic [1:0]        size,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] wdata,
   output logic [BE_W-1:0]   be,
   output logic              aligned
);

   // Replicate the lane so any byte/half position sees the right bytes.
   always_comb begin
      wdata   = '0;
      be      = '0;
      aligned = 1'b0;
      unique case (st_size_e'(size))
         SZ_BYTE: begin
            wdata   = {4{data[7:0]}};
            be      = BE_BYTE0 << addr;
            aligned = 1'b1;
         end
         SZ_HALF: begin
            wdata   = {2{data[15:0]}};
            be      = addr[1] ? BE_HALF_HI : BE_HALF_LO;
            aligned = ~addr[0];
         end
         SZ_WORD: begin
            wdata   = data;
            be      = BE_WORD;
            aligned = (addr == 2'b00);
         end
         default: begin
            wdata   = '0;
            be      = '0;
            aligned = 1'b0;
         end
      endcase
   end

endmodule : store_align

// File: rtl/store_buffer.sv
// store_buffer: MEM-stage store queue draining to data memory.
//   Accepts aligned stores (st_valid/st_ready), flags misaligned ones with a
//   one-cycle st_misalign pulse, holds them pre-aligned in a DEPTH-entry FIFO
//   and presents the head on mem_we/mem_addr/mem_wdata/mem_be until mem_ready.
//   CLK, RST (async active-high); empty/count report occupancy.
//   Optional STORE_BUFFER_HAZARD_EN adds ld_addr (in) / ld_hazard (out,
//   combinational) for load-after-store word-address matching.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 32
) (
   input  logic                     CLK,
   input  logic                     RST,
`ifdef STORE_BUFFER_HAZARD_EN
   input  logic [ADDR_W-1:0]        ld_addr,
   output logic                     ld_hazard,
`endif
   input  logic                     st_valid,
   output logic                     st_ready,
   input  logic [ADDR_W-1:0]        st_addr,
   input  logic [1:0]               st_size,
   input  logic [DATA_W-1:0]        st_data,
   output logic                     st_misalign,
   output logic                     mem_we,
   input  logic                     mem_ready,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   output logic [BE_W-1:0]          mem_be,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned WA_W  = ADDR_W - 2;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             misalign_q, misalign_d;

   logic [WA_W-1:0]  addr_q [DEPTH];
   sb_lane_t         lane_q [DEPTH];

   logic [DATA_W-1:0] al_wdata;
   logic [BE_W-1:0]   al_be;
   logic              al_ok;
   logic              push, pop, is_empty, is_full;

   store_align u_align (
      .addr    (st_addr[1:0]),
      .size    (st_size),
      .data    (st_data),
      .wdata   (al_wdata),
      .be      (al_be),
      .aligned (al_ok)
   );

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CNT_W'(DEPTH));

   // Occupancy status and head-of-queue drain port, zeroed while empty.
   assign empty       = is_empty;
   assign count       = count_q;
   assign st_ready    = ~is_full;
   assign st_misalign = misalign_q;
   assign mem_we      = ~is_empty;
   assign mem_addr    = is_empty ? '0 : {addr_q[rd_ptr_q], 2'b00};
   assign mem_wdata   = is_empty ? '0 : lane_q[rd_ptr_q].wdata;
   assign mem_be      = is_empty ? '0 : lane_q[rd_ptr_q].be;

   // Pointer/count/misalign next state.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      misalign_d = 1'b0;
      push       = st_valid & ~is_full & al_ok;
      pop        = ~is_empty & mem_ready;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // Rejections are only flagged when the buffer could have taken them.
      misalign_d = st_valid & ~is_full & ~al_ok;
   end

   // Control state.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         misalign_q <= misalign_d;
      end
   end

   // Entry storage, written pre-aligned at the tail.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            addr_q[i] <= '0;
            lane_q[i] <= '0;
         end
      end else if (push) begin
         addr_q[wr_ptr_q] <= st_addr[ADDR_W-1:2];
         lane_q[wr_ptr_q] <= '{wdata: al_wdata, be: al_be};
      end
   end

`ifdef STORE_BUFFER_HAZARD_EN
   logic [PTR_W-1:0] hz_off;
   logic             unused_ld_lo;

   assign unused_ld_lo = ^ld_addr[1:0];

   // An entry is live when its distance from the head is below count.
   always_comb begin
      ld_hazard = 1'b0;
      hz_off    = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         hz_off = PTR_W'(PTR_W'(i) - rd_ptr_q);
         if ((CNT_W'(hz_off) < count_q) &&
             (addr_q[i] == ld_addr[ADDR_W-1:2]) &&
             (lane_q[i].be != '0))
            ld_hazard = 1'b1;
      end
   end
`endif

endmodule : store_buffer

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned ADDR_W = 32;

   logic              CLK = 1'b0;
   logic              RST;
   logic              st_valid;
   logic              st_ready;
   logic [31:0]       st_addr;
   logic [1:0]        st_size;
   logic [31:0]       st_data;
   logic              st_misalign;
   logic              mem_we;
   logic              mem_ready;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_be;
   logic              empty;
   logic [2:0]        count;
`ifdef STORE_BUFFER_HAZARD_EN
   logic [31:0]       ld_addr;
   logic              ld_hazard;
`endif

   store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .CLK         (CLK),
      .RST         (RST),
`ifdef STORE_BUFFER_HAZARD_EN
      .ld_addr     (ld_addr),
      .ld_hazard   (ld_hazard),
`endif
      .st_valid    (st_valid),
      .st_ready    (st_ready),
      .st_addr     (st_addr),
      .st_size     (st_size),
      .st_data     (st_data),
      .st_misalign (st_misalign),
      .mem_we      (mem_we),
      .mem_ready   (mem_ready),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_be      (mem_be),
      .empty       (empty),
      .count       (count)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } exp_t;

   exp_t q[$];
   bit   mis_exp;
   int   total;
   int   bad;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Compare every output against the reference queue state.
   task automatic check_outputs();
      exp_t h;
      h = '{addr: 32'h0, wdata: 32'h0, be: 4'h0};
      if (q.size() > 0) h = q[0];
      chk("mem_we",    32'(mem_we),      32'(q.size() > 0));
      chk("mem_addr",  mem_addr,         h.addr);
      chk("mem_wdata", mem_wdata,        h.wdata);
      chk("mem_be",    32'(mem_be),      32'(h.be));
      chk("count",     32'(count),       32'(q.size()));
      chk("empty",     32'(empty),       32'(q.size() == 0));
      chk("st_ready",  32'(st_ready),    32'(q.size() < int'(DEPTH)));
      chk("misalign",  32'(st_misalign), 32'(mis_exp));
`ifdef STORE_BUFFER_HAZARD_EN
      begin
         bit hz;
         hz = 1'b0;
         foreach (q[i]) if ((q[i].addr >> 2) == (ld_addr >> 2)) hz = 1'b1;
         chk("ld_hazard", 32'(ld_hazard), 32'(hz));
      end
`endif
   endtask

   // One clock cycle: drive, check, clock, update the model.
   task automatic cycle(input bit v, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] d, input bit mr);
      bit   rdy, ok, do_push, do_pop;
      exp_t e;
      st_valid  = v;
      st_addr   = a;
      st_size   = sz;
      st_data   = d;
      mem_ready = mr;
      #1;
      check_outputs();
      rdy = q.size() < int'(DEPTH);
      e.addr = a & 32'hFFFF_FFFC;
      case (sz)
         2'd0: begin ok = 1'b1;          e.be = 4'(1 << (a % 4));          e.wdata = 32'(d[7:0])  * 32'h0101_0101; end
         2'd1: begin ok = (a % 2) == 0;  e.be = ((a & 2) != 0) ? 4'd12 : 4'd3; e.wdata = 32'(d[15:0]) * 32'h0001_0001; end
         2'd2: begin ok = (a % 4) == 0;  e.be = 4'd15;                     e.wdata = d; end
         default: begin ok = 1'b0;       e.be = 4'd0;                      e.wdata = 32'h0; end
      endcase
      do_push = v && rdy && ok;
      do_pop  = (q.size() > 0) && mr;
      @(posedge CLK);
      #1;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
      mis_exp = v && rdy && !ok;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      mis_exp = 1'b0;
      RST = 1'b1;
      st_valid = 1'b0; st_addr = '0; st_size = '0; st_data = '0; mem_ready = 1'b0;
`ifdef STORE_BUFFER_HAZARD_EN
      ld_addr = 32'h0;
`endif
      #2;
      check_outputs();
      @(posedge CLK); @(posedge CLK); #1;
      RST = 1'b0;

      // Word store, then idle until drained.
      cycle(1, 32'h100, 2'd2, 32'hDEAD_BEEF, 1);
      cycle(0, 32'h0, 2'd0, 32'h0, 1);
      cycle(0, 32'h0, 2'd0, 32'h0, 1);

      // Byte and half stores held with mem_ready low, then drained.
      cycle(1, 32'h203, 2'd0, 32'h0000_00A5, 0);
      cycle(1, 32'h202, 2'd1, 32'h0000_1234, 0);
`ifdef STORE_BUFFER_HAZARD_EN
      cycle(1, 32'h301, 2'd0, 32'h0000_0077, 0);
      ld_addr = 32'h300;
      cycle(0, 32'h0, 2'd0, 32'h0, 0);
      ld_addr = 32'h304;
      cycle(0, 32'h0, 2'd0, 32'h0, 0);
      ld_addr = 32'h300;
`endif
      for (int i = 0; i < 4; i++) cycle(0, 32'h0, 2'd0, 32'h0, 1);

      // Fill to DEPTH with a fifth request blocked, then drain.
      for (int i = 0; i < 6; i++)
         cycle(1, 32'h400 + 32'(4 * i), 2'd2, 32'h1111_0000 + 32'(i), 0);
      cycle(1, 32'h500, 2'd2, 32'h5555_5555, 1);
      cycle(1, 32'h500, 2'd2, 32'h5555_5555, 1);
      cycle(0, 32'h0, 2'd0, 32'h0, 1);
      for (int i = 0; i < 6; i++) cycle(0, 32'h0, 2'd0, 32'h0, 1);

      // Misaligned half and reserved size: rejected, one-cycle pulse each.
      cycle(1, 32'h101, 2'd1, 32'h0000_BEEF, 0);
      cycle(0, 32'h0, 2'd0, 32'h0, 0);
      cycle(1, 32'h104, 2'd3, 32'hCAFE_CAFE, 0);
      cycle(1, 32'h106, 2'd2, 32'hCAFE_CAFE, 0);
      cycle(0, 32'h0, 2'd0, 32'h0, 0);

      // Push and pop together at count=2.
      cycle(1, 32'h600, 2'd2, 32'h6000_0000, 0);
      cycle(1, 32'h604, 2'd2, 32'h6000_0004, 0);
      cycle(1, 32'h608, 2'd2, 32'h6000_0008, 1);
      cycle(1, 32'h60C, 2'd2, 32'h6000_000C, 1);

      // Asynchronous reset mid-drain.
      #1;
      RST = 1'b1;
      #1;
      chk("rst_async_we",    32'(mem_we), 32'h0);
      chk("rst_async_count", 32'(count),  32'h0);
      q.delete();
      mis_exp = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b0;
      check_outputs();

      // Random traffic against the queue model.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a;
         a = 32'h1000 + 32'($urandom_range(0, 31));
`ifdef STORE_BUFFER_HAZARD_EN
         ld_addr = 32'h1000 + 32'($urandom_range(0, 31));
`endif
         cycle(($urandom % 4) != 0, a, 2'($urandom % 4), $urandom, ($urandom % 3) != 0);
      end
      for (int i = 0; i < 8; i++) cycle(0, 32'h0, 2'd0, 32'h0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_store_buffer

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-side counterpart to the CPU's load-data register: accepts store requests from the MEM stage, aligns data, and generates byte enables.
- Queues stores in a small FIFO and drains them to data memory over a valid/ready write port.
- Sits between the MEM-stage store path and the data-memory write port.
- Frees the pipeline from memory write stalls until the buffer fills.

Parameters:
- DEPTH, 4, number of queued stores; power of two, >= 2.
- ADDR_W, 32, byte-address width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- st_valid  in  1  store request from MEM stage.
- st_ready  out  1  buffer can accept; = !full.
- st_addr  in  ADDR_W  byte address.
- st_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- st_data  in  32  store data, right-justified.
- st_misalign  out  1  one-cycle pulse: previous cycle's request was rejected.
- mem_we  out  1  head entry valid (write request).
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  word-aligned address of head entry (bits [1:0] = 0).
- mem_wdata  out  32  aligned write data.
- mem_be  out  4  byte enables, little-endian.
- empty  out  1  no pending stores (used for SYNC/drain).
- count  out  clog2(DEPTH)+1  number of entries held.

Behaviour:
- Reset (async, RST=1):
  - wr_ptr, rd_ptr and count go to 0; empty=1.
  - mem_we=0; mem_addr, mem_wdata and mem_be = 0; st_misalign=0; st_ready=1.
  - Entries held at reset are discarded.
- Push: a request is pushed when st_valid && st_ready && aligned.
  - Aligned means byte: any address; half: addr[0]=0; word: addr[1:0]=0.
  - Size 11 is never aligned.
- Reject: st_valid && st_ready && !aligned.
  - Nothing is enqueued.
  - st_misalign=1 for exactly the next cycle, then 0.
  - A request presented while st_ready=0 is neither accepted nor flagged.
- Alignment (applied at push, stored pre-aligned):
  - Byte: wdata = {4{d[7:0]}}, be = 0001 << addr[1:0].
  - Half: wdata = {2{d[15:0]}}, be = addr[1] ? 1100 : 0011.
  - Word: wdata = d, be = 1111.
- Drain:
  - mem_we = !empty; mem_addr, mem_wdata and mem_be show the head entry.
  - All drain outputs are 0 when empty.
  - Pop occurs when mem_we && mem_ready; head outputs hold stable until the pop.
- Latency: a store pushed at edge N appears on mem_we in the cycle after edge N. There is no same-cycle bypass.
- Simultaneous push and pop:
  - count is unchanged and both pointers advance.
  - When full, st_ready=0, so a push cannot coincide with the pop. A slot freed at edge N is usable from cycle N+1.
- Full: count == DEPTH gives st_ready=0.
- Empty: mem_ready is ignored.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- Ordering: strictly FIFO. Stores are never merged or reordered.

Optional Feature:
- Macro: STORE_BUFFER_HAZARD_EN.
- Defined: adds ports ld_addr (in, ADDR_W) and ld_hazard (out, 1).
  - ld_hazard is combinational.
  - It is 1 when any valid entry has mem_addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2] and a nonzero be.
  - The hazard unit stalls the load on ld_hazard=1.
  - A store being pushed in the same cycle is not checked.
- Undefined: these ports are absent, and loads must wait for empty.

Decomposition:
- Package store_buffer_pkg:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - BE constants BE_WORD=4'b1111, BE_HALF_LO=4'b0011, BE_HALF_HI=4'b1100.
- Sub-module store_align (combinational):
  - Inputs: addr[1:0], size, data.
  - Outputs: wdata, be, aligned.
  - Instantiated once on the push path.

Test Plan:
- Reset then word store addr=0x100, data=0xDEADBEEF, mem_ready=1:
  - Next cycle: mem_we=1, mem_addr=0x100, mem_be=1111, mem_wdata=0xDEADBEEF.
  - The cycle after: empty=1.
- Byte store addr=0x203, data=0x000000A5:
  - mem_addr=0x200, mem_be=1000, mem_wdata=0xA5A5A5A5.
  - Half store addr=0x202, data=0x1234 → be=1100, wdata=0x12341234.
- mem_ready=0, push 5 word stores with DEPTH=4:
  - Fifth request sees st_ready=0; count=4.
  - Raise mem_ready: writes drain in order 1..4.
  - Fifth is accepted one cycle after the first pop.
- Half store addr=0x101 and size=11 store:
  - Not enqueued; st_misalign=1 for one cycle each; count unchanged.
- Push and pop in the same cycle at count=2:
  - count stays 2; order is preserved.
  - Assert RST mid-drain: mem_we=0 and count=0 immediately, without waiting for CLK.
- With STORE_BUFFER_HAZARD_EN, pending byte store at 0x301, ld_addr=0x300:
  - ld_hazard=1.
  - ld_addr=0x304 gives ld_hazard=0.
  - After the drain, ld_hazard=0.
